pcie_us_cfg_mgmt_target: RTL and testbench
==========================================

// Module: pcie_us_cfg_mgmt_target
// PURPOSE
//  Responder end of the UltraScale+ PCIe cfg_mgmt interface. Models a single-function config
//  dword register file that services the read/write requests fpga_core issues, so the core's
//  cfg_mgmt initiator logic can be emulated without the hard IP. Sits where the PCIe hard IP's
//  cfg_mgmt port would be, on the 250 MHz pcie_user_clk domain.
// PARAMETERS
//  FUNC_NUM     8'd0         function number this target answers to
//  REG_COUNT    64           implemented dwords, addr 0..REG_COUNT-1 (power of 2, 2..1024)
//  RESP_LATENCY 4            cycles from accepted request to done pulse (1..15)
//  VENDOR_ID    16'h1234     read-only value, dword 0 bits [15:0]
//  DEVICE_ID    16'h0001     read-only value, dword 0 bits [31:16]
// PORTS
//  clk                       in   1   clock (pcie_user_clk)
//  rst                       in   1   synchronous active-high reset
//  cfg_mgmt_addr             in   10  dword address
//  cfg_mgmt_function_number  in   8   target function
//  cfg_mgmt_write            in   1   write request, held until done
//  cfg_mgmt_write_data       in   32  write data
//  cfg_mgmt_byte_enable      in   4   per-byte write enable
//  cfg_mgmt_read             in   1   read request, held until done
//  cfg_mgmt_read_data        out  32  read data, valid with done
//  cfg_mgmt_read_write_done  out  1   single-cycle completion pulse
//  err_count                 out  16  protocol-violation counter, saturating
// BEHAVIOUR
//  Interface: one clock, reset synchronous and active-high; clk/rst as above.
//  Reset: read_data=0, done=0, err_count=0, state=IDLE, dwords 1..REG_COUNT-1 = 0.
//  FSM: IDLE -> BUSY -> DONE -> HOLDOFF -> IDLE.
//   IDLE: on (read|write) latch addr, func, be, wdata, op; load cnt=RESP_LATENCY-1; go BUSY.
//   BUSY: decrement cnt; at cnt==0 go DONE. Done asserts exactly RESP_LATENCY cycles after
//    the IDLE accept edge (RESP_LATENCY=1 -> done the cycle after accept).
//   DONE: done=1 for exactly one cycle; write commits this cycle; read_data updates this cycle.
//   HOLDOFF: one cycle, requests ignored so a request held through done is not re-accepted.
//  Simultaneous read&write at accept: write performed, read ignored, err_count+1.
//  Request rules in BUSY: if read and write both drop before done -> abort to IDLE, no
//   commit, no done, err_count+1. Changes to addr/data/be during BUSY are ignored (latched).
//  Addressing: latched func != FUNC_NUM or addr >= REG_COUNT: read returns 32'hFFFFFFFF,
//   write dropped; done still pulses. Dword 0 reads {DEVICE_ID,VENDOR_ID}; writes dropped.
//  Write: byte i updated iff be[i]; be=0 is a legal no-op write with done.
//  read_data holds its last read value across writes and idle; only a completed read changes it.
//  err_count saturates at 16'hFFFF.
//  Reset mid-operation: FSM to IDLE same cycle, pending op discarded, no done, no commit.
// TESTING
//  1. write addr 5 data 32'hDEADBEEF be 4'hF, hold until done; read addr 5 ->
//     done 4 cycles after each accept, read_data=32'hDEADBEEF.
//  2. write addr 5 data 32'h11223344 be 4'b0101 over 32'hDEADBEEF; read -> 32'hDE22BE44.
//  3. read addr 0 -> 32'h00011234; write 0 then read 0 -> still 32'h00011234.
//  4. read addr 64 (REG_COUNT=64) or function_number 8'd1 -> 32'hFFFFFFFF, done pulses;
//     write addr 64 leaves every dword unchanged.
//  5. assert read+write together on addr 7, data 32'hA5A5A5A5 -> dword 7=32'hA5A5A5A5,
//     err_count=1; drop request 2 cycles after accept -> no done, err_count=2.
//  6. hold write continuously for 20 cycles -> done every 6 cycles (accept, 3 BUSY, DONE,
//     HOLDOFF); assert rst during BUSY -> no done, target dword unchanged, err_count=0.

Source files
------------

// File: rtl/pcie_us_cfg_mgmt_target.sv
// Responder end of the UltraScale+ PCIe cfg_mgmt interface: a single-function
// config dword register file with fixed response latency and protocol-error counting.
module pcie_us_cfg_mgmt_target #(
    parameter logic [7:0]  FUNC_NUM     = 8'd0,
    parameter int unsigned REG_COUNT    = 64,
    parameter int unsigned RESP_LATENCY = 4,
    parameter logic [15:0] VENDOR_ID    = 16'h1234,
    parameter logic [15:0] DEVICE_ID    = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  cfg_mgmt_addr,
    input  logic [7:0]  cfg_mgmt_function_number,
    input  logic        cfg_mgmt_write,
    input  logic [31:0] cfg_mgmt_write_data,
    input  logic [3:0]  cfg_mgmt_byte_enable,
    input  logic        cfg_mgmt_read,
    output logic [31:0] cfg_mgmt_read_data,
    output logic        cfg_mgmt_read_write_done,
    output logic [15:0] err_count
);

    localparam int unsigned AW       = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [3:0]  CNT_LOAD = 4'(RESP_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE,
        ST_HOLDOFF
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [9:0]   addr_q, addr_d;
    logic [7:0]   func_q, func_d;
    logic [3:0]   be_q, be_d;
    logic [31:0]  wdata_q, wdata_d;
    logic         wr_q, wr_d;
    logic [31:0]  read_data_q, read_data_d;
    logic [15:0]  err_q, err_d;
    logic [31:0]  mem_q [REG_COUNT];
    logic [31:0]  mem_d [REG_COUNT];

    logic          hit;
    logic [AW-1:0] idx;
    logic [31:0]   rd_value;
    logic          err_inc;

    // Decode the latched request: target match and the value a read would return.
    always_comb begin
        idx = addr_q[AW-1:0];
        hit = (func_q == FUNC_NUM) && ({22'd0, addr_q} < 32'(REG_COUNT));
        if (!hit) begin
            rd_value = '1;
        end else if (addr_q == '0) begin
            rd_value = {DEVICE_ID, VENDOR_ID};
        end else begin
            rd_value = mem_q[idx];
        end
    end

    // Next-state, request latching, commit and error accounting.
    // BUSY lasts RESP_LATENCY-1 cycles (leave when cnt reaches 1), so DONE lands
    // RESP_LATENCY cycles after accept; latency 1 skips BUSY entirely.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        func_d      = func_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        read_data_d = read_data_q;
        err_d       = err_q;
        mem_d       = mem_q;
        err_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_mgmt_read || cfg_mgmt_write) begin
                    addr_d  = cfg_mgmt_addr;
                    func_d  = cfg_mgmt_function_number;
                    be_d    = cfg_mgmt_byte_enable;
                    wdata_d = cfg_mgmt_write_data;
                    wr_d    = cfg_mgmt_write;
                    err_inc = cfg_mgmt_read && cfg_mgmt_write;
                    cnt_d   = CNT_LOAD;
                    state_d = (RESP_LATENCY <= 1) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (!cfg_mgmt_read && !cfg_mgmt_write) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_HOLDOFF;
                if (wr_q) begin
                    if (hit && (addr_q != '0)) begin
                        for (int unsigned b = 0; b < 4; b++) begin
                            if (be_q[b]) begin
                                mem_d[idx][8*b +: 8] = wdata_q[8*b +: 8];
                            end
                        end
                    end
                end else begin
                    read_data_d = rd_value;
                end
            end
            ST_HOLDOFF: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (err_inc && (err_q != '1)) begin
            err_d = err_q + 16'd1;
        end
    end

    // State and register-file flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            func_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            read_data_q <= '0;
            err_q       <= '0;
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            func_q      <= func_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            read_data_q <= read_data_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
        end
    end

    // Read data is presented during the done cycle and held afterwards.
    assign cfg_mgmt_read_data       = (state_q == ST_DONE && !wr_q) ? rd_value : read_data_q;
    assign cfg_mgmt_read_write_done = (state_q == ST_DONE);
    assign err_count                = err_q;

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_target.sv
// Scoreboard bench for pcie_us_cfg_mgmt_target: the driver queues the expected
// read_data for every completion, the monitor checks each done pulse against it.
module tb_pcie_us_cfg_mgmt_target;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  addr;
    logic [7:0]  fn;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic [31:0] read_data;
    logic        done;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    pcie_us_cfg_mgmt_target #(
        .FUNC_NUM     (8'd0),
        .REG_COUNT    (64),
        .RESP_LATENCY (LAT),
        .VENDOR_ID    (16'h1234),
        .DEVICE_ID    (16'h0001)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .cfg_mgmt_addr            (addr),
        .cfg_mgmt_function_number (fn),
        .cfg_mgmt_write           (wr),
        .cfg_mgmt_write_data      (wdata),
        .cfg_mgmt_byte_enable     (be),
        .cfg_mgmt_read            (rd),
        .cfg_mgmt_read_data       (read_data),
        .cfg_mgmt_read_write_done (done),
        .err_count                (err_count)
    );

    always #2 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
            end else begin
                chk("read_data", read_data, exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input string name, input logic r, input logic w, input logic [9:0] a,
                         input logic [7:0] f, input logic [31:0] d, input logic [3:0] b,
                         input logic [31:0] exp);
        int n;
        bit seen;
        if (r && !w) last_rd = exp;
        exp_q.push_back(last_rd);
        @(negedge clk);
        rd = r; wr = w; addr = a; fn = f; wdata = d; be = b;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) seen = 1;
        end
        rd = 1'b0;
        wr = 1'b0;
        checks++;
        if (!seen || n != LAT) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles (seen=%0d) expected %0d", name, n, seen, LAT);
            if (!seen && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        last_rd = '0;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; fn = '0; wdata = '0; be = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_done", {31'd0, done}, 32'h0);
        chk("reset_err", {16'd0, err_count}, 32'h0);

        // Full write then readback
        do_op("wr5_full", 1'b0, 1'b1, 10'd5, 8'd0, 32'hDEADBEEF, 4'hF, 32'h0);
        do_op("rd5_a", 1'b1, 1'b0, 10'd5, 8'd0, 32'h0, 4'h0, 32'hDEADBEEF);
        // Partial byte enables
        do_op("wr5_be5", 1'b0, 1'b1, 10'd5, 8'd0, 32'h11223344, 4'b0101, 32'h0);
        do_op("rd5_b", 1'b1, 1'b0, 10'd5, 8'd0, 32'h0, 4'h0, 32'hDE22BE44);
        // ID dword is read-only
        do_op("rd0_a", 1'b1, 1'b0, 10'd0, 8'd0, 32'h0, 4'h0, 32'h00011234);
        do_op("wr0", 1'b0, 1'b1, 10'd0, 8'd0, 32'hFFFFFFFF, 4'hF, 32'h0);
        do_op("rd0_b", 1'b1, 1'b0, 10'd0, 8'd0, 32'h0, 4'h0, 32'h00011234);
        // Out-of-range address and wrong function
        do_op("rd64", 1'b1, 1'b0, 10'd64, 8'd0, 32'h0, 4'h0, 32'hFFFFFFFF);
        do_op("rd_fn1", 1'b1, 1'b0, 10'd5, 8'd1, 32'h0, 4'h0, 32'hFFFFFFFF);
        do_op("wr69", 1'b0, 1'b1, 10'd69, 8'd0, 32'hCAFEF00D, 4'hF, 32'h0);
        do_op("wr_fn1", 1'b0, 1'b1, 10'd5, 8'd1, 32'h0BADF00D, 4'hF, 32'h0);
        do_op("wr_be0", 1'b0, 1'b1, 10'd5, 8'd0, 32'h00000000, 4'h0, 32'h0);
        do_op("rd5_c", 1'b1, 1'b0, 10'd5, 8'd0, 32'h0, 4'h0, 32'hDE22BE44);
        // Highest implemented dword
        do_op("wr63", 1'b0, 1'b1, 10'd63, 8'd0, 32'h12345678, 4'hF, 32'h0);
        do_op("rd63", 1'b1, 1'b0, 10'd63, 8'd0, 32'h0, 4'h0, 32'h12345678);
        // Read and write together: write wins, one error
        do_op("rw7", 1'b1, 1'b1, 10'd7, 8'd0, 32'hA5A5A5A5, 4'hF, 32'h0);
        chk("err_after_rw", {16'd0, err_count}, 32'd1);
        do_op("rd7", 1'b1, 1'b0, 10'd7, 8'd0, 32'h0, 4'h0, 32'hA5A5A5A5);

        // Abort: request dropped two cycles after accept
        @(negedge clk);
        rd = 1'b1; addr = 10'd7; fn = 8'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rd = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("err_after_abort", {16'd0, err_count}, 32'd2);
        chk("read_data_hold", read_data, 32'hA5A5A5A5);

        // Write held for 20 cycles: done every 6 cycles starting at cycle LAT
        repeat (3) exp_q.push_back(last_rd);
        @(negedge clk);
        wr = 1'b1; addr = 10'd9; fn = 8'd0; wdata = 32'h00000055; be = 4'hF;
        dones = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                dones++;
                chk("held_done_cycle", n, LAT + 6 * (dones - 1));
            end
        end
        chk("held_done_count", dones, 3);

        // Reset while the fourth request is in BUSY
        rst = 1'b1;
        wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_rd = '0;
        chk("midrst_err", {16'd0, err_count}, 32'h0);
        chk("midrst_read_data", read_data, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_done", {31'd0, done}, 32'h0);
        do_op("rd9_after_rst", 1'b1, 1'b0, 10'd9, 8'd0, 32'h0, 4'h0, 32'h0);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
